// File: rtl/hex_display_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hex_display_bank                                                 |
// | Brief   : Registered active-low 7-segment bank with blanking, blink, lamp  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hex_display_bank #(
  parameter int DIGITS        = 8,
  parameter int BLINK_DIV     = 25_000_000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  CLOCK_50,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic                  LOAD,
  input  logic                  DEC_MODE,
  input  logic [DIGITS-1:0]     BLINK_EN,
  input  logic                  LAMP_TEST,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int              CNT_W      = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]      C_SEG_OFF  = 7'b1111111;
  localparam logic [6:0]      C_SEG_DASH = 7'b0111111;

  logic [4*DIGITS-1:0] vreg_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                w_wrap;
  logic [DIGITS:0]     w_keep;

  function automatic logic [6:0] f_decode(input logic [3:0] nib, input logic dec);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b0100111;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    if (dec && (nib > 4'd9)) begin
      seg = C_SEG_DASH;
    end
    return seg;
  endfunction

  assign w_wrap  = (cnt_q == C_CNT_LAST);
  assign cnt_d   = w_wrap ? '0 : cnt_q + 1'b1;
  assign phase_d = phase_q ^ w_wrap;

  // w_keep[i] is set when nibble i or any more-significant nibble is non-zero;
  // an invalid decimal nibble is already non-zero, so it keeps lower zeros visible.
  assign w_keep[DIGITS] = 1'b0;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_nib;
      logic       w_lz_blank;
      logic       w_blink_blank;

      assign w_nib         = vreg_q[4*gi +: 4];
      assign w_keep[gi]    = w_keep[gi+1] | (w_nib != 4'd0);
      assign w_lz_blank    = BLANK_LEADING && (gi != 0) && !w_keep[gi];
      assign w_blink_blank = phase_q & BLINK_EN[gi];

      assign hex_d[7*gi +: 7] = LAMP_TEST     ? 7'b0000000 :
                                w_blink_blank ? C_SEG_OFF  :
                                w_lz_blank    ? C_SEG_OFF  :
                                                f_decode(w_nib, DEC_MODE);
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      vreg_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hex_q   <= '1;
    end else begin
      if (LOAD) begin
        vreg_q <= VALUE;
      end
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
    end
  end

  assign HEX = hex_q;

endmodule
`default_nettype wire
